axi3_identity_device: RTL and testbench
=======================================

// Module: axi3_identity_device
// PURPOSE
//  Simulation AXI3 slave that terminates the write buffer's memory side. It collects each
//  write burst into one cache line and presents that line on line_recv for one cycle, so a
//  bench can check every write-back. Reads are answered with "identity" data: each beat
//  carries its own byte address. No backing memory.
// PARAMETERS
//  BUS_WIDTH   4    AXI ID width (awid/wid/bid/arid/rid)
//  ADDR_WIDTH  32   AXI address width
//  DATA_WIDTH  32   AXI data beat width; strobe width is DATA_WIDTH/8
//  LINE_WIDTH  256  cache line width; BEATS = LINE_WIDTH/DATA_WIDTH (8)
// PORTS
//  clk            in   1           single clock, rising edge
//  rst            in   1           synchronous reset, active-high
//  axi3_wr_if     slave modport  aw{id,addr,len[3:0],size,burst,valid,ready},
//                                w{id,data,strb,last,valid,ready}, b{id,resp[1:0],valid,ready}
//  axi3_rd_if     slave modport  ar{id,addr,len[3:0],size,burst,valid,ready},
//                                r{id,data,resp[1:0],last,valid,ready}
//  line_recv      out  LINE_WIDTH  last completed write line; beat k occupies [DATA_WIDTH*k +: DATA_WIDTH]
//  line_recv_vld  out  1           one-cycle pulse; line_recv is valid in that cycle
// BEHAVIOUR
//  Reset: every output 0 (awready, wready, bvalid, arready, rvalid, rlast, line_recv_vld,
//    line_recv); both FSMs go to IDLE; any burst in flight is dropped with no response.
//  Write FSM: IDLE -> DATA -> RESP -> IDLE.
//   IDLE: awready=1. On awvalid&&awready: latch awid, clear the line buffer, beat counter=0,
//     go to DATA.
//   DATA: wready=1. Each wvalid&&wready writes wdata to word (counter mod BEATS); bytes with
//     wstrb=0 keep their value; counter increments. wid and awlen are not checked; wlast alone
//     ends the burst.
//   Last beat (wlast handshake): next cycle line_recv = assembled line including the last
//     beat; line_recv_vld=1 for exactly that one cycle; go to RESP.
//   RESP: bvalid=1, bid=latched id, bresp=2'b00 (OKAY); hold until bready, then IDLE.
//   Minimum burst turnaround: AW 1 cycle, then N W cycles, then >=1 B cycle.
//   A short burst (awlen+1 < BEATS) leaves the unwritten words 0.
//  Read FSM: IDLE -> DATA -> IDLE, fully independent of the write FSM; AW and AR handshakes
//   in the same cycle are both accepted.
//   IDLE: arready=1. On the handshake, latch arid, araddr, arlen; beat i=0.
//   DATA: rvalid=1 starting the cycle after the AR handshake; rid=latched id; rresp=OKAY.
//     rdata = (araddr & ~(DATA_WIDTH/8-1)) + i*(DATA_WIDTH/8), truncated to DATA_WIDTH
//     (INCR only; the burst type is ignored). rlast=1 when i==arlen.
//     Hold rdata/rlast until rready; then i++. After the rlast handshake, go to IDLE.
//   Address arithmetic wraps modulo 2^ADDR_WIDTH.
//  line_recv holds its value between pulses. Consumers sample it only while line_recv_vld=1.
// CONFIGURATION
//  IDENTITY_DEV_STALL_EN defined: back-pressure mode.
//   - wready and rvalid assert only on cycles where a free-running 1-bit toggle (reset 0) is 1;
//     W/R throughput halves.
//   - bvalid is delayed by 2 cycles after entering RESP.
//   - Data values and line_recv_vld semantics are unchanged.
//  Not defined: full-throughput behaviour as above.
// TESTING
//  1) 8-beat write to 0x1000, wdata=0x0..0x7, wstrb=0xF, bready=1 ->
//     line_recv_vld pulses 1 cycle after wlast; line_recv=0x00000007_..._00000000; bid=awid, bresp=0.
//  2) Two back-to-back 8-beat writes with distinct data -> two separate 1-cycle pulses in order,
//     each line exact; awready=0 from AW accept until the bready handshake.
//  3) wstrb=0x1 on beat 2 (wdata=0xAABBCCDD) -> word 2 = 0x000000DD.
//  4) AR araddr=0x2004, arlen=3 -> rdata 0x2004, 0x2008, 0x200C, 0x2010; rlast on the 4th beat;
//     rready toggling holds data stable.
//  5) AW and AR handshakes in the same cycle -> both bursts complete correctly and independently.
//  6) rst asserted mid-write burst -> all outputs 0 next cycle, no line_recv_vld; the next full
//     burst then delivers a correct line.

Source files
------------

// File: rtl/axi3_identity_device.sv
// -----------------------------------------------------------------------------
// axi3_identity_device
//
// Simulation AXI3 slave that terminates the memory side of a write buffer.
//  - Write channel: each AW/W burst is assembled into one cache line. One cycle
//    after the wlast handshake the line appears on line_recv together with a
//    single-cycle line_recv_vld pulse, then an OKAY response is returned on B.
//  - Read channel: "identity" data. Every R beat carries its own beat-aligned
//    byte address (INCR arithmetic, wrapping modulo 2^ADDR_WIDTH).
//  - There is no backing memory; writes and reads are unrelated.
//
// Ports
//  clk, rst         single rising-edge clock, synchronous active-high reset
//  aw*              write address channel (slave side)
//  w*               write data channel (slave side)
//  b*               write response channel (slave side)
//  ar*              read address channel (slave side)
//  r*               read data channel (slave side)
//  line_recv        last completed write line, beat k at [DATA_WIDTH*k +: DATA_WIDTH]
//  line_recv_vld    one-cycle pulse, line_recv valid in that cycle
//
// Build option
//  IDENTITY_DEV_STALL_EN  back-pressure mode: wready/rvalid only on alternate
//                         cycles and bvalid delayed two cycles into RESP.
//                         Undefined: full-throughput behaviour.
// -----------------------------------------------------------------------------
module axi3_identity_device #(
  parameter int BUS_WIDTH  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  // write address
  input  logic [BUS_WIDTH-1:0]    awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [3:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  // write data
  input  logic [BUS_WIDTH-1:0]    wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  // write response
  output logic [BUS_WIDTH-1:0]    bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  // read address
  input  logic [BUS_WIDTH-1:0]    arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [3:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  // read data
  output logic [BUS_WIDTH-1:0]    rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,
  // assembled write line
  output logic [LINE_WIDTH-1:0]   line_recv,
  output logic                    line_recv_vld
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BEATS = LINE_WIDTH / DATA_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LOW_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP     = ADDR_WIDTH'(BYTES);

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  // Merge one data beat into word idx of a line, honouring the byte strobes.
  function automatic logic [LINE_WIDTH-1:0] merge_beat(
    input logic [LINE_WIDTH-1:0] line,
    input logic [CNT_W-1:0]      idx,
    input logic [DATA_WIDTH-1:0] data,
    input logic [BYTES-1:0]      strb
  );
    logic [LINE_WIDTH-1:0] res;
    res = line;
    for (int b = 0; b < BYTES; b++) begin
      if (strb[b]) begin
        res[int'(idx) * DATA_WIDTH + b * 8 +: 8] = data[b * 8 +: 8];
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Internal state
  // ---------------------------------------------------------------------------
  wr_state_t               wr_state_r;
  wr_state_t               wr_state_nxt_s;
  rd_state_t               rd_state_r;
  rd_state_t               rd_state_nxt_s;

  logic                    awready_r;
  logic                    wready_r;
  logic                    bvalid_r;
  logic [BUS_WIDTH-1:0]    bid_r;
  logic                    awready_nxt_s;
  logic                    wready_nxt_s;
  logic                    bvalid_nxt_s;

  logic [LINE_WIDTH-1:0]   line_buf_r;
  logic [LINE_WIDTH-1:0]   line_merged_s;
  logic [CNT_W-1:0]        beat_cnt_r;
  logic [LINE_WIDTH-1:0]   line_recv_r;
  logic                    line_recv_vld_r;

  logic                    arready_r;
  logic                    rvalid_r;
  logic                    rlast_r;
  logic [BUS_WIDTH-1:0]    rid_r;
  logic [ADDR_WIDTH-1:0]   rd_addr_r;
  logic [3:0]              rd_len_r;
  logic [3:0]              rd_beat_r;
  logic                    arready_nxt_s;
  logic                    rvalid_nxt_s;

  logic                    aw_hs_s;
  logic                    w_hs_s;
  logic                    b_hs_s;
  logic                    ar_hs_s;
  logic                    r_hs_s;

  // Pacing qualifiers: always open in full-throughput mode.
  logic                    stall_open_nxt_s;
  logic                    resp_open_s;

  // Fields the device deliberately ignores (address/len on writes, size/burst, wid).
  logic                    unused_s;
  assign unused_s = ^{awaddr, awlen, awsize, awburst, wid, arsize, arburst};

  assign aw_hs_s = awvalid && awready_r;
  assign w_hs_s  = wvalid  && wready_r;
  assign b_hs_s  = bvalid_r && bready;
  assign ar_hs_s = arvalid && arready_r;
  assign r_hs_s  = rvalid_r && rready;

`ifdef IDENTITY_DEV_STALL_EN
  logic       toggle_r;
  logic [1:0] resp_cnt_r;

  // Free-running toggle and RESP dwell counter used to throttle the channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_r   <= 1'b0;
      resp_cnt_r <= 2'd0;
    end else begin
      toggle_r <= ~toggle_r;
      if (wr_state_r != WR_RESP) begin
        resp_cnt_r <= 2'd0;
      end else if (resp_cnt_r != 2'd3) begin
        resp_cnt_r <= resp_cnt_r + 2'd1;
      end else begin
        resp_cnt_r <= resp_cnt_r;
      end
    end
  end

  // Outputs are registered, so they must match the toggle value of the next cycle;
  // bvalid rises in the third RESP cycle (counter already 1 when it is registered).
  always_comb begin
    stall_open_nxt_s = ~toggle_r;
    if ((wr_state_r == WR_RESP) && (resp_cnt_r >= 2'd1)) begin
      resp_open_s = 1'b1;
    end else begin
      resp_open_s = 1'b0;
    end
  end
`else
  // Full-throughput mode: no throttling.
  always_comb begin
    stall_open_nxt_s = 1'b1;
    resp_open_s      = 1'b1;
  end
`endif

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_r <= WR_IDLE;
    end else begin
      wr_state_r <= wr_state_nxt_s;
    end
  end

  // Write FSM next-state logic; wlast alone terminates a burst.
  always_comb begin
    wr_state_nxt_s = wr_state_r;
    case (wr_state_r)
      WR_IDLE: begin
        if (aw_hs_s) wr_state_nxt_s = WR_DATA;
        else         wr_state_nxt_s = WR_IDLE;
      end
      WR_DATA: begin
        if (w_hs_s && wlast) wr_state_nxt_s = WR_RESP;
        else                 wr_state_nxt_s = WR_DATA;
      end
      WR_RESP: begin
        if (b_hs_s) wr_state_nxt_s = WR_IDLE;
        else        wr_state_nxt_s = WR_RESP;
      end
      default: wr_state_nxt_s = WR_IDLE;
    endcase
  end

  // Write FSM outputs, decoded from the next state so they can be registered.
  always_comb begin
    awready_nxt_s = (wr_state_nxt_s == WR_IDLE);
    wready_nxt_s  = (wr_state_nxt_s == WR_DATA) && stall_open_nxt_s;
    bvalid_nxt_s  = (wr_state_nxt_s == WR_RESP) && resp_open_s;
  end

  // Strobe-merged line including the beat currently on the W channel.
  assign line_merged_s = merge_beat(line_buf_r, beat_cnt_r, wdata, wstrb);

  // Write channel output registers and line assembly datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      awready_r       <= 1'b0;
      wready_r        <= 1'b0;
      bvalid_r        <= 1'b0;
      bid_r           <= '0;
      line_buf_r      <= '0;
      beat_cnt_r      <= '0;
      line_recv_r     <= '0;
      line_recv_vld_r <= 1'b0;
    end else begin
      awready_r       <= awready_nxt_s;
      wready_r        <= wready_nxt_s;
      bvalid_r        <= bvalid_nxt_s;
      line_recv_vld_r <= w_hs_s && wlast;
      if (aw_hs_s) begin
        bid_r      <= awid;
        line_buf_r <= '0;
        beat_cnt_r <= '0;
      end else if (w_hs_s) begin
        line_buf_r <= line_merged_s;
        // Counter wraps naturally, giving word index modulo BEATS.
        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      end
      if (w_hs_s && wlast) begin
        line_recv_r <= line_merged_s;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_r <= RD_IDLE;
    end else begin
      rd_state_r <= rd_state_nxt_s;
    end
  end

  // Read FSM next-state logic.
  always_comb begin
    rd_state_nxt_s = rd_state_r;
    case (rd_state_r)
      RD_IDLE: begin
        if (ar_hs_s) rd_state_nxt_s = RD_DATA;
        else         rd_state_nxt_s = RD_IDLE;
      end
      RD_DATA: begin
        if (r_hs_s && rlast_r) rd_state_nxt_s = RD_IDLE;
        else                   rd_state_nxt_s = RD_DATA;
      end
      default: rd_state_nxt_s = RD_IDLE;
    endcase
  end

  // Read FSM outputs, decoded from the next state so they can be registered.
  always_comb begin
    arready_nxt_s = (rd_state_nxt_s == RD_IDLE);
    rvalid_nxt_s  = (rd_state_nxt_s == RD_DATA) && stall_open_nxt_s;
  end

  // Read channel output registers and identity address generator.
  always_ff @(posedge clk) begin
    if (rst) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rid_r     <= '0;
      rd_addr_r <= '0;
      rd_len_r  <= 4'd0;
      rd_beat_r <= 4'd0;
    end else begin
      arready_r <= arready_nxt_s;
      rvalid_r  <= rvalid_nxt_s;
      if (ar_hs_s) begin
        rid_r     <= arid;
        rd_addr_r <= araddr & ~ADDR_LOW_MASK;
        rd_len_r  <= arlen;
        rd_beat_r <= 4'd0;
        rlast_r   <= (arlen == 4'd0);
      end else if (r_hs_s) begin
        // Address wraps modulo 2^ADDR_WIDTH by register width.
        rd_addr_r <= rd_addr_r + ADDR_STEP;
        rd_beat_r <= rd_beat_r + 4'd1;
        rlast_r   <= !rlast_r && ((rd_beat_r + 4'd1) == rd_len_r);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign awready       = awready_r;
  assign wready        = wready_r;
  assign bvalid        = bvalid_r;
  assign bid           = bid_r;
  assign bresp         = 2'b00;
  assign arready       = arready_r;
  assign rvalid        = rvalid_r;
  assign rlast         = rlast_r;
  assign rid           = rid_r;
  assign rdata         = DATA_WIDTH'(rd_addr_r);
  assign rresp         = 2'b00;
  assign line_recv     = line_recv_r;
  assign line_recv_vld = line_recv_vld_r;

endmodule

// File: tb/tb_axi3_identity_device.sv
// Directed bench for axi3_identity_device: write-line capture, strobes, short
// bursts, identity reads (incl. address wrap), concurrent AW/AR and mid-burst reset.
module tb_axi3_identity_device;

  logic         clk;
  logic         rst;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [3:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [3:0]   wid;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [3:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [255:0] line_recv;
  logic         line_recv_vld;

  int n_cmp;
  int n_bad;

  logic [31:0] wd [8];
  logic [3:0]  ws [8];

  axi3_identity_device dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .line_recv(line_recv), .line_recv_vld(line_recv_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write burst of nb beats from wd/ws; checks the line pulse and response.
  task automatic wr_burst(input logic [3:0] id, input int nb, input logic [255:0] exp_line);
    int guard;
    awid = id; awaddr = 32'h0000_1000; awlen = 4'(nb - 1); awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 50) begin tick(); guard++; end
    chk("aw_wait", 32'(guard < 50), 32'd1);
    tick();
    awvalid = 1'b0;
    chk("awready_busy", awready, 1'b0);
    for (int k = 0; k < nb; k++) begin
      wdata = wd[k]; wstrb = ws[k]; wlast = (k == nb - 1); wvalid = 1'b1;
      guard = 0;
      while (!wready && guard < 50) begin tick(); guard++; end
      chk("w_wait", 32'(guard < 50), 32'd1);
      chk("vld_early", line_recv_vld, 1'b0);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("line_vld", line_recv_vld, 1'b1);
    chk("line", line_recv, exp_line);
    chk("awready_resp", awready, 1'b0);
    bready = 1'b1;
    guard = 0;
    while (!bvalid && guard < 50) begin tick(); guard++; end
    chk("b_wait", 32'(guard < 50), 32'd1);
    chk("bid", bid, id);
    chk("bresp", bresp, 2'b00);
    tick();
    bready = 1'b0;
    chk("vld_pulse", line_recv_vld, 1'b0);
    chk("bvalid_clr", bvalid, 1'b0);
    chk("awready_idle", awready, 1'b1);
  endtask

  // Identity read burst; with stall set, rready is held low one cycle per beat.
  task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input bit stall);
    int guard;
    logic [31:0] exp;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    guard = 0;
    while (!arready && guard < 50) begin tick(); guard++; end
    chk("ar_wait", 32'(guard < 50), 32'd1);
    tick();
    arvalid = 1'b0;
    exp = addr & 32'hFFFF_FFFC;
    for (int i = 0; i <= int'(len); i++) begin
      if (stall) begin
        rready = 1'b0;
        chk("rvalid_hold", rvalid, 1'b1);
        chk("rdata_hold", rdata, exp);
        tick();
      end
      rready = 1'b1;
      chk("rvalid", rvalid, 1'b1);
      chk("rdata", rdata, exp);
      chk("rlast", rlast, 1'(i == int'(len)));
      chk("rid", rid, id);
      chk("rresp", rresp, 2'b00);
      tick();
      exp = exp + 32'd4;
    end
    rready = 1'b0;
    chk("rvalid_clr", rvalid, 1'b0);
    chk("arready_idle", arready, 1'b1);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    awid = 4'd0; awaddr = 32'd0; awlen = 4'd0; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b0;
    wid = 4'd0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = 4'd0; araddr = 32'd0; arlen = 4'd0; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b0;
    rready = 1'b0;
    tick(); tick();
    // reset state
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_vld", line_recv_vld, 1'b0);
    chk("rst_line", line_recv, 256'd0);
    rst = 1'b0;
    tick();
    chk("idle_awready", awready, 1'b1);
    chk("idle_arready", arready, 1'b1);

    // 1) 8-beat write, data 0..7
    for (int k = 0; k < 8; k++) begin wd[k] = 32'(k); ws[k] = 4'hF; end
    wr_burst(4'h5, 8, {32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1, 32'h0});

    // 2) back-to-back bursts, distinct data
    for (int k = 0; k < 8; k++) begin wd[k] = 32'hA000_0000 + 32'(k); ws[k] = 4'hF; end
    wr_burst(4'h1, 8, {32'hA0000007, 32'hA0000006, 32'hA0000005, 32'hA0000004,
                       32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000});
    for (int k = 0; k < 8; k++) begin wd[k] = 32'h1111_1111 * 32'(k + 1); ws[k] = 4'hF; end
    wr_burst(4'h2, 8, {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
                       32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});

    // 3) partial strobe on beat 2
    for (int k = 0; k < 8; k++) begin wd[k] = 32'(k); ws[k] = 4'hF; end
    wd[2] = 32'hAABB_CCDD; ws[2] = 4'h1;
    wr_burst(4'h3, 8, {32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h000000DD, 32'h1, 32'h0});
    chk("word2", line_recv[64 +: 32], 32'h0000_00DD);

    // short burst: remaining words stay zero
    for (int k = 0; k < 8; k++) begin wd[k] = 32'hC0DE_0000 + 32'(k); ws[k] = 4'hF; end
    wr_burst(4'h4, 3, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000});

    // 4) identity read with rready toggling; unaligned and wrapping addresses
    rd_burst(4'h6, 32'h0000_2004, 4'd3, 1'b1);
    rd_burst(4'h7, 32'h0000_3003, 4'd0, 1'b0);
    rd_burst(4'h8, 32'hFFFF_FFF8, 4'd3, 1'b0);

    // 5) AW and AR accepted in the same cycle
    for (int k = 0; k < 8; k++) begin wd[k] = 32'h5A5A_0000 + 32'(k); ws[k] = 4'hF; end
    fork
      wr_burst(4'h9, 8, {32'h5A5A0007, 32'h5A5A0006, 32'h5A5A0005, 32'h5A5A0004,
                         32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001, 32'h5A5A0000});
      rd_burst(4'hA, 32'h0000_4000, 4'd5, 1'b1);
    join

    // 6) reset in the middle of a write burst
    awid = 4'hB; awaddr = 32'h0000_1000; awlen = 4'd7; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wdata = 32'hDEAD_0000 + 32'(k); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      tick();
    end
    wvalid = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_awready", awready, 1'b0);
    chk("mid_wready", wready, 1'b0);
    chk("mid_bvalid", bvalid, 1'b0);
    chk("mid_arready", arready, 1'b0);
    chk("mid_rvalid", rvalid, 1'b0);
    chk("mid_vld", line_recv_vld, 1'b0);
    chk("mid_line", line_recv, 256'd0);
    rst = 1'b0;
    tick();
    chk("mid_vld_after", line_recv_vld, 1'b0);
    chk("mid_awready_after", awready, 1'b1);
    for (int k = 0; k < 8; k++) begin wd[k] = 32'hBEEF_0010 + 32'(k); ws[k] = 4'hF; end
    wr_burst(4'hC, 8, {32'hBEEF0017, 32'hBEEF0016, 32'hBEEF0015, 32'hBEEF0014,
                       32'hBEEF0013, 32'hBEEF0012, 32'hBEEF0011, 32'hBEEF0010});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
